rom_pattern_serializer: RTL and testbench

- Stage around the team's registered pattern ROM (addr in, q out, 1-clock read latency).
- Upstream side: generates the ROM address sequence 0..2^ADDR_WIDTH-1, optionally looping.
- Downstream side: captures each returned word and shifts it out MSB-first on a single-bit line, one bit per TICK_DIV clocks.
- Drives LED/scope pattern outputs on the Zybo board. The ROM is instantiated beside this block, not inside it.

---
 rtl/rom_pattern_serializer_pkg.sv | 22 ++
 rtl/rom_pattern_serializer_bit_tick_gen.sv | 43 ++++
 rtl/rom_pattern_serializer.sv | 121 ++++++++++++
 tb/tb_rom_pattern_serializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pattern_serializer_pkg.sv
// Shared types and defaults for the ROM pattern serializer and its tick prescaler.
package rom_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int WORDS          = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_pattern_serializer_bit_tick_gen.sv
// Serial bit prescaler: pulses tick on the last clock of each TICK_DIV-clock bit period.
module bit_tick_gen
    import rom_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rom_pattern_serializer.sv
// Walks a registered pattern ROM from address 0 upward and shifts each word out MSB-first.
module rom_pattern_serializer
    import rom_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TICK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  loop,
    input  logic                  stop,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  busy,
    output logic                  done,
    output state_e                dbg_state
);

    localparam int BW = cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0]         BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  tick;

    // Prescaler is held clear outside SHIFT, so every word starts on a fresh bit period.
    bit_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear((state_q != S_SHIFT) || stop),
        .en   (state_q == S_SHIFT),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        if (stop) begin
            state_d    = S_IDLE;
            rom_addr_d = '0;
            shreg_d    = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_FETCH;
                        rom_addr_d = '0;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    shreg_d   = rom_q;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
                S_SHIFT: begin
                    if (tick) begin
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = S_NEXT;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    // Incrementing past the top address wraps to 0, which is what looping wants.
                    if (rom_addr_q != ADDR_MAX || loop) begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    rom_addr_d = '0;
                    state_d    = S_IDLE;
                end
                default: begin
                    state_d    = S_IDLE;
                    rom_addr_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign ser_valid = (state_q == S_SHIFT);
    assign ser_out   = (state_q == S_SHIFT) && shreg_q[DATA_WIDTH-1];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rom_pattern_serializer.sv
// Directed bench: two serializers (TICK_DIV=4 and TICK_DIV=1), each beside a registered pattern ROM.
module tb_rom_pattern_serializer;
    import rom_pkg::*;

    logic clk;
    logic reset;
    logic loop;
    logic stop;
    logic a_start, b_start;

    logic [2:0] a_addr, b_addr;
    logic [7:0] a_rom_q, b_rom_q;
    logic a_ser_out, a_ser_valid, a_busy, a_done;
    logic b_ser_out, b_ser_valid, b_busy, b_done;
    state_e a_dbg_state, b_dbg_state;

    logic [7:0] rom_mem [8];
    logic [7:0] exp_words [8];

    int n_cmp;
    int n_err;
    int edge_cnt;
    int mark;
    bit sel_b;

    logic       obs_valid, obs_out, obs_busy, obs_done;
    logic [2:0] obs_addr;

    rom_pattern_serializer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .TICK_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .loop(loop), .stop(stop),
        .rom_addr(a_addr), .rom_q(a_rom_q), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
        .busy(a_busy), .done(a_done), .dbg_state(a_dbg_state)
    );

    rom_pattern_serializer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .TICK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .loop(loop), .stop(stop),
        .rom_addr(b_addr), .rom_q(b_rom_q), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
        .busy(b_busy), .done(b_done), .dbg_state(b_dbg_state)
    );

    // Registered pattern ROMs, one-clock read latency.
    always @(posedge clk) begin
        a_rom_q <= rom_mem[a_addr];
        b_rom_q <= rom_mem[b_addr];
    end

    always_comb begin
        obs_valid = sel_b ? b_ser_valid : a_ser_valid;
        obs_out   = sel_b ? b_ser_out   : a_ser_out;
        obs_busy  = sel_b ? b_busy      : a_busy;
        obs_done  = sel_b ? b_done      : a_done;
        obs_addr  = sel_b ? b_addr      : a_addr;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic pulse_start();
        if (sel_b) b_start = 1'b1;
        else a_start = 1'b1;
        step();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  obs_busy,  1'b0);
        check({tag, "_valid"}, obs_valid, 1'b0);
        check({tag, "_out"},   obs_out,   1'b0);
        check({tag, "_done"},  obs_done,  1'b0);
        check({tag, "_addr"},  obs_addr,  3'd0);
    endtask

    // Checks every clock of one word's SHIFT phase, leaving the bench in NEXT.
    task automatic shift_word(input logic [7:0] w, input logic [2:0] addr);
        int div;
        div = sel_b ? 1 : 4;
        for (int b = 7; b >= 0; b--) begin
            for (int t = 0; t < div; t++) begin
                check("shift_valid", obs_valid, 1'b1);
                check("shift_bit",   obs_out,   w[b]);
                check("shift_addr",  obs_addr,  addr);
                step();
            end
        end
    endtask

    // NEXT, FETCH, WAIT: three clocks without valid data, leaving the bench in SHIFT.
    task automatic gap(input logic [2:0] next_addr);
        check("next_valid", obs_valid, 1'b0);
        check("next_out",   obs_out,   1'b0);
        check("next_done",  obs_done,  1'b0);
        step();
        check("fetch_valid", obs_valid, 1'b0);
        check("fetch_addr",  obs_addr,  next_addr);
        step();
        check("wait_valid", obs_valid, 1'b0);
        check("wait_busy",  obs_busy,  1'b1);
        step();
    endtask

    task automatic enter_first_word();
        pulse_start();
        check("e0_busy",  obs_busy,  1'b1);
        check("e0_valid", obs_valid, 1'b0);
        check("e0_addr",  obs_addr,  3'd0);
        step();
        check("e1_valid", obs_valid, 1'b0);
        step();
    endtask

    initial begin
        rom_mem   = '{8'h80, 8'hAA, 8'h55, 8'h83, 8'h00, 8'h99, 8'h81, 8'hF0};
        exp_words = '{8'h80, 8'hAA, 8'h55, 8'h83, 8'h00, 8'h99, 8'h81, 8'hF0};
        n_cmp = 0; n_err = 0; edge_cnt = 0; sel_b = 1'b0;
        reset = 1'b1; loop = 1'b0; stop = 1'b0; a_start = 1'b0; b_start = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state on both instances.
        check_idle("rst_a");
        check("rst_a_state", 32'(a_dbg_state), 32'(S_IDLE));
        sel_b = 1'b1;
        check_idle("rst_b");
        check("rst_b_state", 32'(b_dbg_state), 32'(S_IDLE));
        sel_b = 1'b0;

        // Single non-looping pass with full stream, gaps and done timing.
        mark = edge_cnt;
        enter_first_word();
        check("first_valid", obs_valid, 1'b1);
        for (int w = 0; w < WORDS; w++) begin
            shift_word(exp_words[w], 3'(w));
            if (w < WORDS - 1) gap(3'(w + 1));
        end
        check("last_next_valid", obs_valid, 1'b0);
        check("last_next_done",  obs_done,  1'b0);
        step();
        check("done_pulse", obs_done, 1'b1);
        check("done_busy",  obs_busy, 1'b1);
        check("done_latency", edge_cnt - mark, 281);
        step();
        check_idle("after_done");

        // Start and stop together in IDLE stays idle.
        a_start = 1'b1; stop = 1'b1;
        step();
        a_start = 1'b0; stop = 1'b0;
        check_idle("start_stop");
        step();
        check_idle("start_stop2");

        // Loop mode: wrap after word 7, then drop loop during word 2 of the second pass.
        loop = 1'b1;
        enter_first_word();
        for (int w = 0; w < WORDS; w++) begin
            shift_word(exp_words[w], 3'(w));
            gap(3'((w + 1) % WORDS));
        end
        for (int w = 0; w < WORDS; w++) begin
            if (w == 2) loop = 1'b0;
            shift_word(exp_words[w], 3'(w));
            if (w < WORDS - 1) gap(3'(w + 1));
        end
        check("loop_last_next_done", obs_done, 1'b0);
        step();
        check("loop_done_pulse", obs_done, 1'b1);
        step();
        check_idle("loop_after_done");

        // Stop during bit 3 of word 0xAA.
        enter_first_word();
        shift_word(exp_words[0], 3'd0);
        gap(3'd1);
        repeat (13) step();
        check("pre_stop_valid", obs_valid, 1'b1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("stop_mid");
        step();
        check_idle("stop_mid2");

        // Same with reset.
        enter_first_word();
        shift_word(exp_words[0], 3'd0);
        gap(3'd1);
        repeat (13) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("reset_mid");
        step();
        check_idle("reset_mid2");

        // Restart begins at address 0; extra start pulses while busy change nothing.
        enter_first_word();
        shift_word(exp_words[0], 3'd0);
        a_start = 1'b1;
        gap(3'd1);
        shift_word(exp_words[1], 3'd1);
        a_start = 1'b0;
        gap(3'd2);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (31) step();
        gap(3'd3);
        for (int w = 3; w < WORDS; w++) begin
            shift_word(exp_words[w], 3'(w));
            if (w < WORDS - 1) gap(3'(w + 1));
        end
        step();
        check("busy_start_done", obs_done, 1'b1);
        step();
        check_idle("busy_start_idle");

        // TICK_DIV=1 instance: 11-clock word period and 0x55 on consecutive clocks.
        sel_b = 1'b1;
        enter_first_word();
        mark = edge_cnt;
        shift_word(exp_words[0], 3'd0);
        gap(3'd1);
        check("div1_period", edge_cnt - mark, 11);
        shift_word(exp_words[1], 3'd1);
        gap(3'd2);
        shift_word(exp_words[2], 3'd2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("div1_stop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
